// File: rtl/rx_mac_hdr_pkg.sv
// rtl/rx_mac_hdr_pkg.sv - 802.11 header offsets, FC type codes and parser FSM states
package rx_mac_hdr_pkg;

   localparam int OFS_FC    = 0;
   localparam int OFS_ADDR1 = 4;
   localparam int OFS_ADDR2 = 10;
   localparam int OFS_ADDR3 = 16;
   localparam int HDR_LEN   = 24;

   typedef enum logic [1:0] {
      FC_TYPE_MGMT = 2'd0,
      FC_TYPE_CTRL = 2'd1,
      FC_TYPE_DATA = 2'd2
   } fc_type_e;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_BODY = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Only management and data frames are acknowledged; control frames never are.
   function automatic logic type_acks(input logic [1:0] fc_type);
      return (fc_type_e'(fc_type) == FC_TYPE_MGMT) || (fc_type_e'(fc_type) == FC_TYPE_DATA);
   endfunction

endpackage

// File: rtl/rx_hdr_field_cap.sv
// rtl/rx_hdr_field_cap.sv - byte-lane capture of one header field with a one-shot done pulse
module rx_hdr_field_cap import rx_mac_hdr_pkg::*; #(
   parameter int OFFSET = 0,
   parameter int NBYTES = 2,
   parameter int BCNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clr,
   input  logic                  wr,
   input  logic [BCNT_W-1:0]     byte_count,
   input  logic [7:0]            byte_in,
   output logic [8*NBYTES-1:0]   data,
   output logic                  done,
   output logic                  complete
);

   logic last;

   always_comb begin
      last = wr && (byte_count == BCNT_W'(OFFSET + NBYTES - 1));
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         data     <= '0;
         done     <= 1'b0;
         complete <= 1'b0;
      end else begin
         done <= 1'b0;
         if (clr) begin
            data     <= '0;
            complete <= 1'b0;
         end else begin
            for (int i = 0; i < NBYTES; i++) begin
               if (wr && (byte_count == BCNT_W'(OFFSET + i)))
                  data[8*i +: 8] <= byte_in;
            end
            // complete latches so a repeated last byte cannot pulse twice in one frame
            if (last && !complete) begin
               done     <= 1'b1;
               complete <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rx_mac_hdr_parser.sv
// rtl/rx_mac_hdr_parser.sv - 802.11 RX MAC header parser: field capture, addressing, ACK decision, stats
module rx_mac_hdr_parser import rx_mac_hdr_pkg::*; #(
   parameter int BCNT_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [47:0]        mac_addr,
   input  logic               ack_disable,
   input  logic               pkt_header_valid,
   input  logic               pkt_header_valid_strobe,
   input  logic [BCNT_W-1:0]  pkt_len,
   input  logic               byte_in_strobe,
   input  logic [7:0]         byte_in,
   input  logic [BCNT_W-1:0]  byte_count,
   input  logic               fcs_in_strobe,
   input  logic               fcs_ok,
   input  logic               demod_is_ongoing,
   output logic [15:0]        FC_DI,
   output logic               FC_DI_valid,
   output logic [47:0]        addr1,
   output logic               addr1_valid,
   output logic [47:0]        addr2,
   output logic               addr2_valid,
   output logic [47:0]        addr3,
   output logic               addr3_valid,
   output logic               pkt_for_me,
   output logic               ack_req,
   output logic [47:0]        ack_ra,
   output logic [CNT_W-1:0]   rx_ack_cnt,
   output logic [CNT_W-1:0]   rx_fcs_err_cnt
);

   logic [1:0] state;
   logic       demod_d;
   logic       demod_fall;
   logic       hdr_byte;
   logic       a1_last;
   logic       ack_owed;
   logic       fc_cmp, a1_cmp, a2_cmp, a3_cmp;
   logic       unused_sigs;

   assign unused_sigs = ^{pkt_len, fc_cmp, a3_cmp};

   always_comb begin
      demod_fall = demod_d && !demod_is_ongoing;
      // a byte arriving alongside FCS or a new header belongs to no frame we keep
      hdr_byte   = (state == ST_HDR) && byte_in_strobe && !fcs_in_strobe && !pkt_header_valid_strobe;
      a1_last    = hdr_byte && !a1_cmp && (byte_count == BCNT_W'(OFS_ADDR1 + 5));
      ack_owed   = fcs_ok && pkt_for_me && !addr1[0] && type_acks(FC_DI[3:2])
                   && a2_cmp && !ack_disable;
   end

   rx_hdr_field_cap #(.OFFSET(OFS_FC), .NBYTES(2), .BCNT_W(BCNT_W)) u_fc (
      .clk(clk), .rstn(rstn), .clr(pkt_header_valid_strobe), .wr(hdr_byte),
      .byte_count(byte_count), .byte_in(byte_in),
      .data(FC_DI), .done(FC_DI_valid), .complete(fc_cmp)
   );

   rx_hdr_field_cap #(.OFFSET(OFS_ADDR1), .NBYTES(6), .BCNT_W(BCNT_W)) u_addr1 (
      .clk(clk), .rstn(rstn), .clr(pkt_header_valid_strobe), .wr(hdr_byte),
      .byte_count(byte_count), .byte_in(byte_in),
      .data(addr1), .done(addr1_valid), .complete(a1_cmp)
   );

   rx_hdr_field_cap #(.OFFSET(OFS_ADDR2), .NBYTES(6), .BCNT_W(BCNT_W)) u_addr2 (
      .clk(clk), .rstn(rstn), .clr(pkt_header_valid_strobe), .wr(hdr_byte),
      .byte_count(byte_count), .byte_in(byte_in),
      .data(addr2), .done(addr2_valid), .complete(a2_cmp)
   );

   rx_hdr_field_cap #(.OFFSET(OFS_ADDR3), .NBYTES(6), .BCNT_W(BCNT_W)) u_addr3 (
      .clk(clk), .rstn(rstn), .clr(pkt_header_valid_strobe), .wr(hdr_byte),
      .byte_count(byte_count), .byte_in(byte_in),
      .data(addr3), .done(addr3_valid), .complete(a3_cmp)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state          <= ST_IDLE;
         demod_d        <= 1'b0;
         pkt_for_me     <= 1'b0;
         ack_req        <= 1'b0;
         ack_ra         <= '0;
         rx_ack_cnt     <= '0;
         rx_fcs_err_cnt <= '0;
      end else begin
         demod_d <= demod_is_ongoing;
         ack_req <= 1'b0;
         if (pkt_header_valid_strobe) begin
            state      <= pkt_header_valid ? ST_HDR : ST_IDLE;
            pkt_for_me <= 1'b0;
         end else begin
            case (state)
               ST_HDR, ST_BODY: begin
                  if (fcs_in_strobe) begin
                     state <= ST_DONE;
                     if (ack_owed) begin
                        ack_req <= 1'b1;
                        ack_ra  <= addr2;
                        if (rx_ack_cnt != '1)
                           rx_ack_cnt <= rx_ack_cnt + CNT_W'(1);
                     end
                     if (!fcs_ok && (rx_fcs_err_cnt != '1))
                        rx_fcs_err_cnt <= rx_fcs_err_cnt + CNT_W'(1);
                  end else if (demod_fall) begin
                     state <= ST_IDLE;
                  end else if (hdr_byte && (byte_count == BCNT_W'(HDR_LEN - 1))) begin
                     state <= ST_BODY;
                  end
               end
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
            // compare the assembled address with the final byte still on the bus
            if (a1_last)
               pkt_for_me <= ({byte_in, addr1[39:0]} == mac_addr);
         end
      end
   end

endmodule

// File: tb/tb_rx_mac_hdr_parser.sv
// tb/tb_rx_mac_hdr_parser.sv - directed and randomized bench for rx_mac_hdr_parser
module tb_rx_mac_hdr_parser;
   localparam int BW = 16;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam logic [47:0] MAC = 48'hFFEEDDCCBBAA;

   logic clk = 1'b0;
   logic rstn;
   logic [47:0] mac_addr;
   logic ack_disable, pkt_header_valid, pkt_header_valid_strobe;
   logic [BW-1:0] pkt_len, byte_count;
   logic byte_in_strobe;
   logic [7:0] byte_in;
   logic fcs_in_strobe, fcs_ok, demod_is_ongoing;
   logic [15:0] FC_DI;
   logic FC_DI_valid, addr1_valid, addr2_valid, addr3_valid, pkt_for_me, ack_req;
   logic [47:0] addr1, addr2, addr3, ack_ra;
   logic [CW-1:0] rx_ack_cnt, rx_fcs_err_cnt;

   rx_mac_hdr_parser #(.BCNT_W(BW), .CNT_W(CW)) dut (
      .clk(clk), .rstn(rstn), .mac_addr(mac_addr), .ack_disable(ack_disable),
      .pkt_header_valid(pkt_header_valid), .pkt_header_valid_strobe(pkt_header_valid_strobe),
      .pkt_len(pkt_len), .byte_in_strobe(byte_in_strobe), .byte_in(byte_in),
      .byte_count(byte_count), .fcs_in_strobe(fcs_in_strobe), .fcs_ok(fcs_ok),
      .demod_is_ongoing(demod_is_ongoing), .FC_DI(FC_DI), .FC_DI_valid(FC_DI_valid),
      .addr1(addr1), .addr1_valid(addr1_valid), .addr2(addr2), .addr2_valid(addr2_valid),
      .addr3(addr3), .addr3_valid(addr3_valid), .pkt_for_me(pkt_for_me), .ack_req(ack_req),
      .ack_ra(ack_ra), .rx_ack_cnt(rx_ack_cnt), .rx_fcs_err_cnt(rx_fcs_err_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // pulse monitor, sampled mid-cycle
   int m_ack = 0, m_fcv = 0, m_a1v = 0, m_a2v = 0, m_a3v = 0, ack_cyc = 0;
   logic pfm_seen = 1'b0;
   logic [47:0] ra_seen = '0;
   always @(negedge clk) begin
      if (ack_req) begin m_ack++; ack_cyc = cyc; ra_seen = ack_ra; end
      if (FC_DI_valid) m_fcv++;
      if (addr1_valid) begin m_a1v++; pfm_seen = pkt_for_me; end
      if (addr2_valid) m_a2v++;
      if (addr3_valid) m_a3v++;
   end

   int n_pass = 0, n_total = 0, n_fail = 0;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [7:0] fb [0:255];
   logic [7:0] hdr0 [0:23] = '{8'h08, 8'h02, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                               8'hEE, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                               8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00};
   int e_ack_cnt = 0, e_err_cnt = 0;
   logic [47:0] e_ra = '0;
   int s_ack, s_fcv, s_a1v, s_a2v, s_a3v, fcs_cyc;

   function automatic logic [47:0] field48(input int ofs);
      logic [47:0] r;
      for (int i = 0; i < 6; i++) r[8*i +: 8] = fb[ofs + i];
      return r;
   endfunction

   task automatic cycle_();
      @(posedge clk); #1;
      pkt_header_valid_strobe = 1'b0;
      byte_in_strobe = 1'b0;
      fcs_in_strobe = 1'b0;
   endtask

   task automatic load_default();
      for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
      for (int i = 0; i < 24; i++) fb[i] = hdr0[i];
   endtask

   task automatic load_random(output int len);
      int r;
      for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
      r = $urandom_range(0, 4);
      case (r)
         0: fb[0] = 8'h08;
         1: fb[0] = 8'h00;
         2: fb[0] = 8'hB4;
         3: fb[0] = 8'h88;
         default: fb[0] = 8'hD4;
      endcase
      r = $urandom_range(0, 9);
      if (r < 6) for (int i = 0; i < 6; i++) fb[4 + i] = mac_addr[8*i +: 8];
      else if (r < 8) for (int i = 0; i < 6; i++) fb[4 + i] = 8'hFF;
      r = $urandom_range(0, 2);
      len = (r == 0) ? 14 : (r == 1) ? 20 : int'($urandom_range(24, 64));
   endtask

   task automatic snap();
      s_ack = m_ack; s_fcv = m_fcv; s_a1v = m_a1v; s_a2v = m_a2v; s_a3v = m_a3v;
   endtask

   task automatic drive_frame(input int len, input bit fok, input int gap, input int cut);
      snap();
      demod_is_ongoing = 1'b1;
      pkt_header_valid = 1'b1;
      pkt_header_valid_strobe = 1'b1;
      pkt_len = BW'(len);
      cycle_();
      for (int i = 0; i < len; i++) begin
         if (i == cut) return;
         byte_in_strobe = 1'b1;
         byte_in = fb[i];
         byte_count = BW'(i);
         cycle_();
         repeat (gap) cycle_();
      end
      fcs_in_strobe = 1'b1;
      fcs_ok = fok;
      fcs_cyc = cyc;
      cycle_();
      demod_is_ongoing = 1'b0;
      repeat (3) cycle_();
   endtask

   task automatic check_frame(input string tag, input int len, input bit fok);
      logic [15:0] efc;
      logic [47:0] ea1, ea2, ea3;
      bit for_me, owe;
      efc = {fb[1], fb[0]};
      ea1 = field48(4);
      ea2 = field48(10);
      ea3 = field48(16);
      for_me = (len >= 10) && (ea1 == MAC);
      owe = fok && for_me && !ea1[0] && (efc[3:2] == 2'd0 || efc[3:2] == 2'd2)
            && (len >= 16) && !ack_disable;
      if (owe) begin
         e_ack_cnt = (e_ack_cnt < CMAX) ? e_ack_cnt + 1 : CMAX;
         e_ra = ea2;
      end
      if (!fok) e_err_cnt = (e_err_cnt < CMAX) ? e_err_cnt + 1 : CMAX;
      chk({tag, ".fc_pulses"}, 64'(m_fcv - s_fcv), 64'(len >= 2));
      if (len >= 2) chk({tag, ".fc"}, 64'(FC_DI), 64'(efc));
      chk({tag, ".a1_pulses"}, 64'(m_a1v - s_a1v), 64'(len >= 10));
      if (len >= 10) begin
         chk({tag, ".addr1"}, 64'(addr1), 64'(ea1));
         chk({tag, ".for_me_at_valid"}, 64'(pfm_seen), 64'(for_me));
      end
      chk({tag, ".for_me_held"}, 64'(pkt_for_me), 64'(for_me));
      chk({tag, ".a2_pulses"}, 64'(m_a2v - s_a2v), 64'(len >= 16));
      if (len >= 16) chk({tag, ".addr2"}, 64'(addr2), 64'(ea2));
      chk({tag, ".a3_pulses"}, 64'(m_a3v - s_a3v), 64'(len >= 22));
      if (len >= 22) chk({tag, ".addr3"}, 64'(addr3), 64'(ea3));
      chk({tag, ".acks"}, 64'(m_ack - s_ack), 64'(owe));
      if (owe) begin
         chk({tag, ".ack_latency"}, 64'(ack_cyc - fcs_cyc), 64'd1);
         chk({tag, ".ra_at_pulse"}, 64'(ra_seen), 64'(ea2));
      end
      chk({tag, ".ack_ra"}, 64'(ack_ra), 64'(e_ra));
      chk({tag, ".ack_cnt"}, 64'(rx_ack_cnt), 64'(e_ack_cnt));
      chk({tag, ".err_cnt"}, 64'(rx_fcs_err_cnt), 64'(e_err_cnt));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".fc"}, 64'(FC_DI), 64'd0);
      chk({tag, ".addr1"}, 64'(addr1), 64'd0);
      chk({tag, ".addr2"}, 64'(addr2), 64'd0);
      chk({tag, ".addr3"}, 64'(addr3), 64'd0);
      chk({tag, ".pulses"}, 64'({FC_DI_valid, addr1_valid, addr2_valid, addr3_valid, ack_req}), 64'd0);
      chk({tag, ".for_me"}, 64'(pkt_for_me), 64'd0);
      chk({tag, ".ack_ra"}, 64'(ack_ra), 64'd0);
      chk({tag, ".cnts"}, 64'({rx_ack_cnt, rx_fcs_err_cnt}), 64'd0);
   endtask

   initial begin
      int len, gap, r_ack, r_a2v;
      bit fok;
      rstn = 1'b0; mac_addr = MAC; ack_disable = 1'b0;
      pkt_header_valid = 1'b0; pkt_header_valid_strobe = 1'b0; pkt_len = '0;
      byte_in_strobe = 1'b0; byte_in = '0; byte_count = '0;
      fcs_in_strobe = 1'b0; fcs_ok = 1'b0; demod_is_ongoing = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rstn = 1'b1;
      cycle_();

      load_default(); drive_frame(128, 1'b1, 0, -1); check_frame("ucast", 128, 1'b1);
      chk("ucast.fc_plan", 64'(FC_DI), 64'h0208);
      chk("ucast.addr2_plan", 64'(addr2), 64'h665544332211);
      chk("ucast.addr3_plan", 64'(addr3), 64'hCCBBAA998877);
      chk("ucast.ra_plan", 64'(ack_ra), 64'h665544332211);

      load_default(); drive_frame(128, 1'b0, 0, -1); check_frame("fcserr", 128, 1'b0);
      load_default(); fb[4] = 8'hAB; drive_frame(40, 1'b1, 0, -1); check_frame("foreign", 40, 1'b1);
      load_default(); for (int i = 4; i < 10; i++) fb[i] = 8'hFF;
      drive_frame(40, 1'b1, 0, -1); check_frame("bcast", 40, 1'b1);
      load_default(); fb[0] = 8'hB4; drive_frame(40, 1'b1, 0, -1); check_frame("rts", 40, 1'b1);
      load_default(); fb[0] = 8'hC4; drive_frame(14, 1'b1, 0, -1); check_frame("cts", 14, 1'b1);

      // abort at byte 12; later strobes must find the parser idle
      load_default(); drive_frame(128, 1'b1, 0, 13);
      demod_is_ongoing = 1'b0;
      repeat (3) cycle_();
      r_a2v = m_a2v;
      for (int i = 13; i < 16; i++) begin
         byte_in_strobe = 1'b1; byte_in = fb[i]; byte_count = BW'(i); cycle_();
      end
      byte_in_strobe = 1'b1; byte_in = 8'h00; byte_count = BW'(4); cycle_();
      fcs_in_strobe = 1'b1; fcs_ok = 1'b0; cycle_();
      repeat (3) cycle_();
      chk("abort.acks", 64'(m_ack - s_ack), 64'd0);
      chk("abort.a2_pulses", 64'(m_a2v - r_a2v), 64'd0);
      chk("abort.addr1_kept", 64'(addr1), 64'(MAC));
      chk("abort.ack_cnt", 64'(rx_ack_cnt), 64'(e_ack_cnt));
      chk("abort.err_cnt", 64'(rx_fcs_err_cnt), 64'(e_err_cnt));

      r_ack = m_ack;
      load_default(); drive_frame(128, 1'b1, 0, 51);
      drive_frame(128, 1'b1, 0, -1); check_frame("restart", 128, 1'b1);
      chk("restart.total_acks", 64'(m_ack - r_ack), 64'd1);

      load_default(); drive_frame(48, 1'b1, 3, -1); check_frame("gap", 48, 1'b1);

      for (int k = 0; k < 40; k++) begin
         load_random(len);
         ack_disable = ($urandom_range(0, 9) == 0);
         fok = ($urandom_range(0, 3) != 0);
         gap = $urandom_range(0, 2);
         drive_frame(len, fok, gap, -1);
         check_frame($sformatf("rnd%0d", k), len, fok);
      end
      ack_disable = 1'b0;

      for (int k = 0; k < 18; k++) begin
         load_default(); drive_frame(24, 1'b1, 0, -1); check_frame("sat_ack", 24, 1'b1);
      end
      chk("sat.ack_final", 64'(rx_ack_cnt), 64'(CMAX));
      for (int k = 0; k < 17; k++) begin
         load_default(); drive_frame(24, 1'b0, 0, -1); check_frame("sat_err", 24, 1'b0);
      end
      chk("sat.err_final", 64'(rx_fcs_err_cnt), 64'(CMAX));

      // reset in the middle of the header
      load_default(); drive_frame(40, 1'b1, 0, 12);
      rstn = 1'b0;
      cycle_();
      chk_zero("midrst");
      rstn = 1'b1;
      e_ack_cnt = 0; e_err_cnt = 0; e_ra = '0;
      r_a2v = m_a2v;
      for (int i = 12; i < 16; i++) begin
         byte_in_strobe = 1'b1; byte_in = fb[i]; byte_count = BW'(i); cycle_();
      end
      repeat (2) cycle_();
      chk("midrst.a2_pulses", 64'(m_a2v - r_a2v), 64'd0);
      chk("midrst.addr2", 64'(addr2), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
